// File: rtl/arb_request_ctrl.sv
// Requester-side controller for the thermometer round-robin arbiter: holds one descriptor
// per port, locks the winner for a whole packet and polices the returned grant vector.
module arb_request_ctrl #(
    parameter int unsigned PORTS = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PORTS-1:0]       pkt_valid,
    input  logic [PORTS*LEN_W-1:0] pkt_len,
    output logic [PORTS-1:0]       pkt_ready,
    output logic [PORTS-1:0]       request,
    input  logic [PORTS-1:0]       grant,
    input  logic                   any_grant,
    output logic                   flit_valid,
    output logic [PORTS-1:0]       flit_src,
    output logic                   flit_tail,
    output logic                   proto_err
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e             state_q, state_d;
    logic [PORTS-1:0]   pending_q, pending_d;
    logic [LEN_W-1:0]   len_q [PORTS];
    logic [PORTS-1:0]   owner_q, owner_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               flit_valid_q, flit_valid_d;
    logic [PORTS-1:0]   flit_src_q, flit_src_d;
    logic               flit_tail_q, flit_tail_d;
    logic               proto_err_q, proto_err_d;

    logic [PORTS-1:0]   enq;
    logic [PORTS-1:0]   clear_mask;
    logic [LEN_W-1:0]   sel_len;
    logic               grant_err;
    logic               grant_fire;
    logic               tail_fire;

    assign pkt_ready  = ~pending_q;
    assign request    = (state_q == StIdle) ? pending_q : (pending_q & owner_q);
    assign flit_valid = flit_valid_q;
    assign flit_src   = flit_src_q;
    assign flit_tail  = flit_tail_q;
    assign proto_err  = proto_err_q;

    assign enq = pkt_valid & ~pending_q;

    // Length of the granted port; grant is one-hot whenever this value is used.
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_len = sel_len | len_q[i];
            end
        end
    end

    always_comb begin
        grant_err = 1'b0;
        if ((grant & (grant - PORTS'(1))) != '0) grant_err = 1'b1;
        if ((grant & ~request) != '0)            grant_err = 1'b1;
        if (state_q == StLock && grant != '0 && grant != owner_q) grant_err = 1'b1;
        if (any_grant != (|grant))               grant_err = 1'b1;
    end

    assign grant_fire = !grant_err && (grant != '0);
    assign tail_fire  = grant_fire &&
                        (((state_q == StIdle) && (sel_len == LEN_W'(1))) ||
                         ((state_q == StLock) && (remaining_q == LEN_W'(1))));
    assign clear_mask = tail_fire ? grant : '0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        remaining_d  = remaining_q;
        flit_valid_d = 1'b0;
        flit_src_d   = '0;
        flit_tail_d  = 1'b0;
        pending_d    = (pending_q & ~clear_mask) | enq;
        proto_err_d  = proto_err_q | grant_err | ((pkt_valid & pending_q) != '0);

        if (grant_fire) begin
            flit_valid_d = 1'b1;
            flit_src_d   = grant;
            flit_tail_d  = tail_fire;
            unique case (state_q)
                StIdle: begin
                    owner_d     = grant;
                    remaining_d = sel_len - LEN_W'(1);
                    if (!tail_fire) state_d = StLock;
                end
                StLock: begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (tail_fire) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            owner_q      <= '0;
            remaining_q  <= '0;
            flit_valid_q <= 1'b0;
            flit_src_q   <= '0;
            flit_tail_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            for (int i = 0; i < PORTS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            owner_q      <= owner_d;
            remaining_q  <= remaining_d;
            flit_valid_q <= flit_valid_d;
            flit_src_q   <= flit_src_d;
            flit_tail_q  <= flit_tail_d;
            proto_err_q  <= proto_err_d;
            // Zero-length descriptors are stored as single-flit packets.
            for (int i = 0; i < PORTS; i++) begin
                if (enq[i]) begin
                    len_q[i] <= (pkt_len[i*LEN_W +: LEN_W] == '0) ? LEN_W'(1)
                                                                  : pkt_len[i*LEN_W +: LEN_W];
                end
            end
        end
    end

endmodule

// File: doc/arb_request_ctrl.md
Name: arb_request_ctrl

Overview:
- Requester-side companion to the router's thermometer round-robin arbiter.
- Holds one pending packet descriptor per input port and drives the arbiter's request vector. It consumes the returned grant vector and emits a one-hot flit-source select for the crossbar.
- Locks the winning port for the whole packet by requesting only the owner's bit until the tail flit. This keeps wormhole packets from interleaving.
- Checks the arbiter's grant against protocol: at most one grant, and no grant without a request.

Parameters:
- PORTS, 8: number of requesting input ports; width of request/grant.
- LEN_W, 4: width of each packet-length field, in flits. A length of 0 is treated as 1.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pkt_valid  input  PORTS  per-port pulse: a new packet descriptor is offered
- pkt_len  input  PORTS*LEN_W  per-port packet length; port i occupies bits [i*LEN_W +: LEN_W]
- pkt_ready  output  PORTS  port i can accept a descriptor (equals !pending[i])
- request  output  PORTS  request vector to the arbiter
- grant  input  PORTS  grant vector from the arbiter, combinational in the same cycle as request
- any_grant  input  1  arbiter's any-grant indication
- flit_valid  output  1  a flit is forwarded this cycle
- flit_src  output  PORTS  one-hot source port of the current flit; all zeros when idle
- flit_tail  output  1  current flit is the last flit of its packet
- proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, high): pending=0, len regs=0, state=IDLE, owner=0, remaining=0. Outputs: request=0, flit_valid=0, flit_src=0, flit_tail=0, proto_err=0, pkt_ready=all ones.
- Enqueue: pkt_valid[i] && pkt_ready[i] at a clk edge sets pending[i] and stores len[i] (0 is stored as 1).
  - pkt_valid[i] while pending[i]=1: descriptor dropped, proto_err set.
- State machine, 2 states:
  - IDLE: request = pending. If grant is one-hot and grant ⊆ request:
    - owner <= grant, remaining <= len[owner]-1.
    - Next cycle: flit_valid=1, flit_src=grant, flit_tail=(len==1).
    - If len==1: clear pending[owner] at that same edge and stay IDLE. Otherwise go to LOCK.
  - LOCK: request = owner only; all other pending bits are masked. Each cycle grant==owner:
    - Emit one flit the next cycle and decrement remaining.
    - When remaining==1: that flit has flit_tail=1, pending[owner] clears, state returns to IDLE.
    - grant==0 in LOCK: no flit, no decrement.
- Latency: pkt_valid at cycle t → request at t+1 → grant at t+1 → first flit_valid at t+2. In LOCK, back-to-back grants give one flit per cycle.
- Outputs flit_valid, flit_src and flit_tail are registered. request is combinational from state registers only, never from grant.
- Error checks, each evaluated every cycle; any failure sets proto_err (sticky until reset):
  - grant not onehot0.
  - grant bit set where request is 0.
  - In LOCK, grant ≠ owner and ≠ 0.
  - any_grant ≠ |grant.
  - Offending grants emit no flit and do not change state.
- Simultaneous events:
  - Enqueue on a port not currently pending is accepted in the same cycle another port is granted.
  - The owner's pkt_ready stays 0 through its tail cycle. A new descriptor is accepted only from the cycle after the tail grant.
- Reset mid-packet: the packet is abandoned, and all pending descriptors and the lock are cleared immediately.
- remaining is LEN_W bits wide; no wrap is possible because it is loaded from len-1 ≥ 0.

Test Plan:
- Single 1-flit packet:
  - Stimulus: reset, then pkt_valid=8'h04 with len=1; bench grants request combinationally.
  - Required: request=8'h04 at t+1; flit_valid=1, flit_src=8'h04, flit_tail=1 at t+2; request=0 and pkt_ready[2]=1 at t+3.
- Packet lock:
  - Stimulus: port 1 len=3 and port 5 len=2 enqueued together; arbiter grants port 1 first.
  - Required: request=8'h02 during LOCK; flits src 02,02,02 with tail only on the third; then request=8'h20; two flits src 20 with tail on the second. No interleaving.
- Length 0:
  - Stimulus: port 0 len=0.
  - Required: exactly one flit, flit_tail=1.
- Overflow:
  - Stimulus: second pkt_valid on port 3 while pending[3]=1.
  - Required: proto_err=1 next cycle; only one packet is forwarded from port 3.
- Bad grants:
  - Stimulus: inject grant=8'h03, then grant=8'h80 with request=8'h01.
  - Required: proto_err=1; no flit_valid; state unchanged.
- Reset mid-packet:
  - Stimulus: port 6 len=8, assert reset after 3 flits.
  - Required: same-cycle request=0, flit_valid=0, pkt_ready=8'hFF, proto_err=0.
